vec_col_sequencer: RTL and testbench

Sequences multi-cycle vector instructions through the SIMD AES datapath one column at a time. It accepts one decoded instruction per handshake. Scalar instructions pass through as a single micro-op. Vector or column instructions are expanded into NCOLS column micro-ops, followed by a writeback drain. It sits between fetch/decode and the vector register file/ALU, and drives the fetch stall.

---
 rtl/vec_seq_pkg.sv | 23 ++
 rtl/vec_seq_counter.sv | 35 +++
 rtl/vec_col_sequencer.sv | 168 ++++++++++++++++
 tb/tb_vec_col_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/vec_seq_pkg.sv
// Shared types and constants for the vector column sequencer.
package vec_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

  localparam int unsigned NCOLS_DEFAULT  = 4;
  localparam int unsigned WB_LAT_DEFAULT = 2;
  localparam int unsigned OPCODE_MSB     = 19;
  localparam int unsigned OPCODE_LSB     = 15;
  // Drain counter width, sized for WB_LAT up to 7.
  localparam int unsigned DRAIN_W        = 3;

  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] get_opcode(
    input logic [OPCODE_MSB:0] instr
  );
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/vec_seq_counter.sv
// Loadable up/down counter with enable; load has priority over counting.
module vec_seq_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = up ? count_q + Width'(1) : count_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vec_col_sequencer.sv
// Expands vector instructions into per-column micro-ops plus a writeback drain.
// Optional performance counters are built when VEC_SEQ_PERF_EN is defined.
module vec_col_sequencer
  import vec_seq_pkg::*;
#(
  parameter int unsigned BITS   = 20,
  parameter int unsigned NCOLS  = NCOLS_DEFAULT,
  parameter int unsigned WB_LAT = WB_LAT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BITS-1:0]          instr,
  input  logic                     vregwrite,
  input  logic                     colread,
  input  logic                     colwrite,
  input  logic                     hold,
  input  logic                     flush,
  output logic                     uop_valid,
  output logic [BITS-1:0]          uop_instr,
  output logic [$clog2(NCOLS)-1:0] col_idx,
  output logic                     col_rd_en,
  output logic                     col_wr_en,
  output logic                     vreg_we,
  output logic                     stall,
`ifdef VEC_SEQ_PERF_EN
  output logic [31:0]              perf_vec_cnt,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_hold_cnt,
`endif
  output logic                     done
);

  localparam int unsigned CW = $clog2(NCOLS);
  localparam logic [CW-1:0] LastCol = CW'(NCOLS - 1);
  localparam logic [DRAIN_W-1:0] DrainLoad = DRAIN_W'(WB_LAT);

  state_e            state_q;
  logic [BITS-1:0]   instr_q;
  logic              vregwrite_q, colread_q, colwrite_q;
  logic [CW-1:0]     col;
  logic [DRAIN_W-1:0] drain_cnt;

  logic is_vec, accept, advance, last_col, drain_last;
  logic col_en, drain_load, drain_en;

  assign is_vec     = vregwrite | colread | colwrite;
  assign in_ready   = (state_q == StIdle) && !flush;
  assign accept     = in_valid && in_ready;
  // Flush overrides everything, so it also blocks progress.
  assign advance    = !hold && !flush;
  assign last_col   = (col == LastCol);
  assign drain_last = (drain_cnt == DRAIN_W'(1));
  assign col_en     = (state_q == StIssue) && advance;
  assign drain_load = col_en && last_col;
  assign drain_en   = (state_q == StDrain) && advance;

  vec_seq_counter #(
    .Width (CW)
  ) u_col_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val ('0),
    .en       (col_en),
    .up       (1'b1),
    .count    (col)
  );

  vec_seq_counter #(
    .Width (DRAIN_W)
  ) u_drain_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (drain_load),
    .load_val (DrainLoad),
    .en       (drain_en),
    .up       (1'b0),
    .count    (drain_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      instr_q     <= '0;
      vregwrite_q <= 1'b0;
      colread_q   <= 1'b0;
      colwrite_q  <= 1'b0;
    end else begin
      if (accept && is_vec) begin
        instr_q     <= instr;
        vregwrite_q <= vregwrite;
        colread_q   <= colread;
        colwrite_q  <= colwrite;
      end
      if (flush) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle:  if (accept && is_vec) state_q <= StIssue;
          StIssue: if (advance && last_col) state_q <= (WB_LAT > 0) ? StDrain : StIdle;
          StDrain: if (advance && drain_last) state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_comb begin
    uop_valid = 1'b0;
    uop_instr = '0;
    col_idx   = '0;
    col_rd_en = 1'b0;
    col_wr_en = 1'b0;
    vreg_we   = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Scalar pass-through retires in the accept cycle.
        if (accept && !is_vec) begin
          uop_valid = 1'b1;
          uop_instr = instr;
          done      = 1'b1;
        end
      end
      StIssue: begin
        stall   = 1'b1;
        col_idx = col;
        if (advance) begin
          uop_valid = 1'b1;
          uop_instr = instr_q;
          col_rd_en = colread_q;
          col_wr_en = colwrite_q;
          vreg_we   = vregwrite_q;
          done      = last_col && (WB_LAT == 0);
        end
      end
      StDrain: begin
        stall = 1'b1;
        done  = advance && drain_last;
      end
      default: ;
    endcase
  end

`ifdef VEC_SEQ_PERF_EN
  logic [31:0] perf_vec_q, perf_stall_q, perf_hold_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_vec_q   <= '0;
      perf_stall_q <= '0;
      perf_hold_q  <= '0;
    end else begin
      if (done && (state_q != StIdle) && (perf_vec_q != '1)) perf_vec_q <= perf_vec_q + 32'd1;
      if (stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
      if (stall && hold && (perf_hold_q != '1)) perf_hold_q <= perf_hold_q + 32'd1;
    end
  end

  assign perf_vec_cnt   = perf_vec_q;
  assign perf_stall_cnt = perf_stall_q;
  assign perf_hold_cnt  = perf_hold_q;
`endif

endmodule

// File: tb/tb_vec_col_sequencer.sv
// Bench for vec_col_sequencer: two instances (WB_LAT=2 and WB_LAT=0) against a slot-queue model.
module tb_vec_col_sequencer;

  localparam int NC = 4;

  typedef struct packed {
    logic       is_uop;
    logic [1:0] col;
    logic       fin;
  } slot_t;

  logic        clk, rst_n, in_valid, vregwrite, colread, colwrite, hold, flush;
  logic [19:0] instr;

  logic        rdy [2];
  logic        uv  [2];
  logic [19:0] ui  [2];
  logic [1:0]  ci  [2];
  logic        rde [2];
  logic        wre [2];
  logic        vwe [2];
  logic        stl [2];
  logic        dn  [2];

  vec_col_sequencer #(.BITS(20), .NCOLS(NC), .WB_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .instr(instr),
    .vregwrite(vregwrite), .colread(colread), .colwrite(colwrite), .hold(hold), .flush(flush),
    .uop_valid(uv[0]), .uop_instr(ui[0]), .col_idx(ci[0]), .col_rd_en(rde[0]),
    .col_wr_en(wre[0]), .vreg_we(vwe[0]), .stall(stl[0]), .done(dn[0])
  );

  vec_col_sequencer #(.BITS(20), .NCOLS(NC), .WB_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .instr(instr),
    .vregwrite(vregwrite), .colread(colread), .colwrite(colwrite), .hold(hold), .flush(flush),
    .uop_valid(uv[1]), .uop_instr(ui[1]), .col_idx(ci[1]), .col_rd_en(rde[1]),
    .col_wr_en(wre[1]), .vreg_we(vwe[1]), .stall(stl[1]), .done(dn[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each accepted vector instruction becomes a list of work slots
  // (NC column uops, then WB_LAT drain slots); every non-held cycle consumes one.
  slot_t       slots [2][16];
  int          head [2];
  int          len  [2];
  int          wb   [2];
  logic [19:0] m_instr [2];
  logic        m_rd [2], m_wr [2], m_we [2];

  int    checks = 0, passed = 0, cyc = 0;
  int    done_seen, uops_seen;
  string phase = "reset";

  function automatic logic [28:0] model_exp(input int k);
    logic rdy_e = 1'b0, uv_e = 1'b0, rd_e = 1'b0, wr_e = 1'b0, we_e = 1'b0;
    logic stl_e = 1'b0, dn_e = 1'b0;
    logic [19:0] ui_e = '0;
    logic [1:0]  ci_e = '0;
    logic adv = !hold && !flush;
    slot_t f;
    if (len[k] == 0) begin
      rdy_e = !flush;
      if (in_valid && !flush && !(vregwrite | colread | colwrite)) begin
        uv_e = 1'b1;
        ui_e = instr;
        dn_e = 1'b1;
      end
    end else begin
      stl_e = 1'b1;
      f = slots[k][head[k]];
      if (f.is_uop) ci_e = f.col;
      if (adv && f.is_uop) begin
        uv_e = 1'b1;
        ui_e = m_instr[k];
        rd_e = m_rd[k];
        wr_e = m_wr[k];
        we_e = m_we[k];
      end
      dn_e = adv && f.fin;
    end
    return {rdy_e, uv_e, ui_e, ci_e, rd_e, wr_e, we_e, stl_e, dn_e};
  endfunction

  task automatic model_tick(input int k);
    if (!rst_n || flush) begin
      len[k] = 0;
    end else if (len[k] == 0) begin
      if (in_valid && (vregwrite | colread | colwrite)) begin
        m_instr[k] = instr;
        m_rd[k]    = colread;
        m_wr[k]    = colwrite;
        m_we[k]    = vregwrite;
        head[k]    = 0;
        for (int c = 0; c < NC; c++)
          slots[k][c] = '{is_uop: 1'b1, col: 2'(c), fin: (wb[k] == 0) && (c == NC - 1)};
        for (int d = 0; d < wb[k]; d++)
          slots[k][NC + d] = '{is_uop: 1'b0, col: 2'd0, fin: (d == wb[k] - 1)};
        len[k] = NC + wb[k];
      end
    end else if (!hold) begin
      head[k]++;
      len[k]--;
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input logic iv, input logic [19:0] ins, input logic vw, input logic cr,
                      input logic cw, input logic h, input logic f, input logic r);
    logic [28:0] obs, exp;
    @(negedge clk);
    in_valid = iv; instr = ins; vregwrite = vw; colread = cr; colwrite = cw;
    hold = h; flush = f; rst_n = r;
    #1;
    for (int k = 0; k < 2; k++) begin
      exp = model_exp(k);
      obs = {rdy[k], uv[k], ui[k], ci[k], rde[k], wre[k], vwe[k], stl[k], dn[k]};
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s wb=%0d cyc=%0d got %h expected %h", phase, wb[k], cyc, obs, exp);
    end
    if (dn[0] === 1'b1 && done_seen < 0) done_seen = cyc;
    if (uv[0] === 1'b1) uops_seen++;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_tick(k);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int acc;
    wb[0] = 2; wb[1] = 0;
    len[0] = 0; len[1] = 0; head[0] = 0; head[1] = 0;
    in_valid = 0; instr = '0; vregwrite = 0; colread = 0; colwrite = 0;
    hold = 0; flush = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    step(1'b0, 20'h12345, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    phase = "scalar";
    for (int i = 0; i < 3; i++) step(1'b1, 20'($urandom()), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);

    phase = "vec_rd_we";
    done_seen = -1; uops_seen = 0; acc = cyc;
    step(1'b1, 20'hA5A5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(9);
    check_int("vec_done_latency", done_seen - acc, 6);
    check_int("vec_uop_count", uops_seen, 4);

    phase = "vec_hold";
    done_seen = -1; uops_seen = 0; acc = cyc;
    step(1'b1, 20'h5A5A5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(8);
    check_int("hold_done_latency", done_seen - acc, 9);
    check_int("hold_uop_count", uops_seen, 4);

    phase = "flush";
    done_seen = -1;
    step(1'b1, 20'h0F0F0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_int("flush_no_done", done_seen, -1);
    step(1'b1, 20'h13579, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);

    phase = "rst_drain";
    done_seen = -1;
    step(1'b1, 20'hBEEF1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    check_int("rst_no_done", done_seen, -1);

    phase = "wb0_colwrite";
    step(1'b1, 20'hC0DE0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(4);
    for (int i = 0; i < 10; i++) step(1'b1, 20'hC0DE0 + 20'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(8);

    phase = "random";
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 2) != 0), 20'($urandom()),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 63) != 0));
    end
    idle(8);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
